design_switch_controller: RTL
=============================

# design_switch_controller

Parametrised successor to the top-level design selector. It multiplexes `NUM_DESIGNS` user designs onto the shared GPIO bank and drives their active-low chip selects. Unlike a purely combinational selector, it synchronises and debounces `design_select`. Every change of design passes through a guard interval: all chip selects are deasserted and all pads are tri-stated (inputs) before the new design is enabled. It sits between the caravel-facing GPIO pads and the per-design wrappers.

## Interface
- `NUM_DESIGNS`, 12: number of attached designs, numbered 1..`NUM_DESIGNS`. Select value 0 means no design.
- `SEL_W`, 4: width of `design_select`. Requires 2^`SEL_W` > `NUM_DESIGNS`.
- `GPIO_W`, 34: GPIO bank width.
- `STABLE_CYCLES`, 2: consecutive identical synchronised samples required before a select value is accepted. Must be ≥1.
- `GUARD_CYCLES`, 4: length of the guard interval in cycles. Must be ≥1.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `design_select`  in  `SEL_W`: requested design. Asynchronous to `clk`.
- `designs_gpio_out`  in  `NUM_DESIGNS*GPIO_W`: design k drives slice [(k-1)*GPIO_W +: GPIO_W].
- `designs_gpio_oeb`  in  `NUM_DESIGNS*GPIO_W`: same slicing as `designs_gpio_out`.
- `designs_ncs`  out  `NUM_DESIGNS`: bit k-1 is the active-low chip select of design k.
- `gpio_out`  out  `GPIO_W`: registered pad output.
- `gpio_oeb`  out  `GPIO_W`: registered pad output enable, active low.
- `active_design`  out  `SEL_W`: design currently enabled. 0 when none is enabled.
- `switching`  out  1: high while in GUARD.

## Operation
- Reset values (asynchronous): state OFF; `active_design`=0; `target`=0; `designs_ncs` all 1; `gpio_out` all 0; `gpio_oeb` all 1; `switching`=0; synchroniser, candidate, count and `sel_stable` all 0.
- Input path:
  - 2-flop synchroniser produces `sel_sync`.
  - Candidate filter: if `sel_sync` ≠ `candidate`, load `candidate` ← `sel_sync` and `cnt` ← 1.
  - Otherwise, increment `cnt`, saturating at `STABLE_CYCLES`.
  - When the registered `cnt` == `STABLE_CYCLES` and `candidate` ≠ `sel_stable`, load `sel_stable` ← `candidate`.
- A select value is valid iff 1 ≤ value ≤ `NUM_DESIGNS`.
- FSM states: OFF, GUARD, ACTIVE.
  - OFF → GUARD: when `sel_stable` is valid. Latch `target` ← `sel_stable`, clear `guard_cnt`.
  - ACTIVE → GUARD: when `sel_stable` ≠ `active_design`. Latch `target` ← `sel_stable`, which may be invalid or 0.
  - GUARD → GUARD (restart): if `sel_stable` ≠ `target`, reload `target`, clear `guard_cnt`. The interval restarts at full length.
  - GUARD exit: when `guard_cnt` == `GUARD_CYCLES`-1. Go to ACTIVE with `active_design` ← `target` if `target` is valid. Otherwise go to OFF with `active_design` ← 0.
  - `sel_stable` == `active_design` in ACTIVE: no action.
  - `sel_stable` 0 or invalid in OFF: no action.
- Outputs (all registered):
  - In ACTIVE: `designs_ncs[active_design-1]`=0, all other bits 1.
  - In OFF and GUARD: all `designs_ncs` bits 1.
  - `gpio_out`/`gpio_oeb` are sampled each edge from the slice of `active_design` while the registered state is ACTIVE. Otherwise they load 0 / all-ones.
- No path exists by which two chip selects are low at once, or by which a design's pads are driven in any cycle in which its chip select is high, apart from the one-cycle registered pad lag described under Timing.

## Timing
- A `design_select` change first sampled at edge 1 reaches `sel_stable` at edge 3+S, where S=`STABLE_CYCLES`.
- The FSM enters GUARD at edge 4+S. At that same edge `designs_ncs` goes all-high and `switching` rises.
- The FSM enters ACTIVE at edge 4+S+G, where G=`GUARD_CYCLES`. At that edge the new chip select goes low and `switching` falls.
- Pads reflect the new design from edge 5+S+G. That is a one-cycle registered lag after chip-select assertion.
- On leaving ACTIVE, pads go safe (out 0, oeb 1) at edge 5+S. This is one cycle after the chip select deasserts.
- Select glitches shorter than S consecutive synchronised samples are ignored. A partially counted candidate is discarded when a different value arrives.
- Asserting `rst` mid-GUARD or mid-ACTIVE forces the reset values immediately. After release the controller re-acquires `design_select` from scratch.

## Test plan
- Defaults S=2, G=4; `design_select`=3 held from reset release. Required: `designs_ncs`=all-ones until GUARD completes; then bit 2 goes low with `active_design`=3; `gpio_out`/`gpio_oeb` equal design 3's slice one cycle later.
- Switch 3→7 while ACTIVE. Required: all chip selects high at edge 6 after sampling; `ncs[6]` low at edge 10; pads show design 7 at edge 11; `switching` high for exactly 4 cycles.
- Select pulses to 5 for 1 cycle while design 3 is ACTIVE. Required: no state change; `active_design` stays 3; `switching` never rises.
- Select 3→9, then →2 during GUARD. Required: guard restarts at 4 full cycles from the re-latch; final `active_design`=2; design 9 is never enabled.
- Select 0 or 13 from ACTIVE. Required: GUARD, then OFF; `active_design`=0; `gpio_oeb`=all-ones; `gpio_out`=0.
- Assert `rst` in the middle of GUARD. Required: outputs return to reset values asynchronously in the same cycle; after release, normal acquisition latency applies.

Source files
------------

// File: rtl/design_switch_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : design_switch_controller                                        |
// | Purpose  : Debounced design selector that muxes NUM_DESIGNS user designs   |
// |            onto a shared GPIO bank, with a chip-select guard interval.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module design_switch_controller #(
    parameter int NUM_DESIGNS   = 12,
    parameter int SEL_W         = 4,
    parameter int GPIO_W        = 34,
    parameter int STABLE_CYCLES = 2,
    parameter int GUARD_CYCLES  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SEL_W-1:0]              design_select,
    input  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_out,
    input  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_oeb,
    output logic [NUM_DESIGNS-1:0]        designs_ncs,
    output logic [GPIO_W-1:0]             gpio_out,
    output logic [GPIO_W-1:0]             gpio_oeb,
    output logic [SEL_W-1:0]              active_design,
    output logic                          switching
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int GC_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    localparam logic [1:0]       c_st_off     = 2'd0;
    localparam logic [1:0]       c_st_guard   = 2'd1;
    localparam logic [1:0]       c_st_active  = 2'd2;
    localparam logic [CNT_W-1:0] c_stable     = CNT_W'(STABLE_CYCLES);
    localparam logic [GC_W-1:0]  c_guard_last = GC_W'(GUARD_CYCLES - 1);
    localparam logic [SEL_W-1:0] c_max_sel    = SEL_W'(NUM_DESIGNS);

    logic [SEL_W-1:0]       r_sync1;
    logic [SEL_W-1:0]       r_sync2;
    logic [SEL_W-1:0]       r_candidate;
    logic [CNT_W-1:0]       r_cnt;
    logic [SEL_W-1:0]       r_sel_stable;

    logic [1:0]             r_state;
    logic [SEL_W-1:0]       r_target;
    logic [GC_W-1:0]        r_guard_cnt;
    logic [SEL_W-1:0]       r_active;

    logic [NUM_DESIGNS-1:0] r_ncs;
    logic [GPIO_W-1:0]      r_gpio_out;
    logic [GPIO_W-1:0]      r_gpio_oeb;
    logic                   r_switching;

    logic [1:0]             w_state_next;
    logic [SEL_W-1:0]       w_target_next;
    logic [GC_W-1:0]        w_guard_next;
    logic [SEL_W-1:0]       w_active_next;
    logic [NUM_DESIGNS-1:0] w_ncs_next;
    logic [GPIO_W-1:0]      w_pad_out;
    logic [GPIO_W-1:0]      w_pad_oeb;
    logic                   w_stable_valid;
    logic                   w_target_valid;

    assign w_stable_valid = (r_sel_stable != '0) && (r_sel_stable <= c_max_sel);
    assign w_target_valid = (r_target != '0) && (r_target <= c_max_sel);

    // Synchroniser followed by a run-length filter on the synchronised value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_candidate  <= '0;
            r_cnt        <= '0;
            r_sel_stable <= '0;
        end else begin
            r_sync1 <= design_select;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_candidate) begin
                r_candidate <= r_sync2;
                r_cnt       <= CNT_W'(1);
            end else if (r_cnt != c_stable) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_cnt == c_stable) && (r_candidate != r_sel_stable)) begin
                r_sel_stable <= r_candidate;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_off;
            r_target    <= '0;
            r_guard_cnt <= '0;
            r_active    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_target    <= w_target_next;
            r_guard_cnt <= w_guard_next;
            r_active    <= w_active_next;
        end
    end

    // A target change during GUARD takes priority over exit, restarting the interval
    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_guard_next  = r_guard_cnt;
        w_active_next = r_active;
        case (r_state)
            c_st_off: begin
                if (w_stable_valid) begin
                    w_state_next  = c_st_guard;
                    w_target_next = r_sel_stable;
                    w_guard_next  = '0;
                end
            end
            c_st_guard: begin
                if (r_sel_stable != r_target) begin
                    w_target_next = r_sel_stable;
                    w_guard_next  = '0;
                end else if (r_guard_cnt == c_guard_last) begin
                    if (w_target_valid) begin
                        w_state_next  = c_st_active;
                        w_active_next = r_target;
                    end else begin
                        w_state_next  = c_st_off;
                        w_active_next = '0;
                    end
                end else begin
                    w_guard_next = r_guard_cnt + GC_W'(1);
                end
            end
            c_st_active: begin
                if (r_sel_stable != r_active) begin
                    w_state_next  = c_st_guard;
                    w_target_next = r_sel_stable;
                    w_guard_next  = '0;
                end
            end
            default: begin
                w_state_next  = c_st_off;
                w_active_next = '0;
            end
        endcase
    end

    // Chip selects follow the next state so they drop on the same edge as the FSM
    always_comb begin
        w_ncs_next = '1;
        for (int k = 0; k < NUM_DESIGNS; k++) begin
            if ((w_state_next == c_st_active) && (w_active_next == SEL_W'(k + 1))) begin
                w_ncs_next[k] = 1'b0;
            end
        end
    end

    // Pads follow the registered state, lagging chip-select assertion by one cycle
    always_comb begin
        w_pad_out = '0;
        w_pad_oeb = '1;
        if (r_state == c_st_active) begin
            for (int k = 0; k < NUM_DESIGNS; k++) begin
                if (r_active == SEL_W'(k + 1)) begin
                    w_pad_out = designs_gpio_out[k*GPIO_W +: GPIO_W];
                    w_pad_oeb = designs_gpio_oeb[k*GPIO_W +: GPIO_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ncs       <= '1;
            r_gpio_out  <= '0;
            r_gpio_oeb  <= '1;
            r_switching <= 1'b0;
        end else begin
            r_ncs       <= w_ncs_next;
            r_gpio_out  <= w_pad_out;
            r_gpio_oeb  <= w_pad_oeb;
            r_switching <= (w_state_next == c_st_guard);
        end
    end

    assign designs_ncs   = r_ncs;
    assign gpio_out      = r_gpio_out;
    assign gpio_oeb      = r_gpio_oeb;
    assign active_design = r_active;
    assign switching     = r_switching;

endmodule
`default_nettype wire
